// File: rtl/bin2bcd_seq.sv
// Iterative 14-bit binary to 4-digit packed BCD converter (double dabble, one bit per clock).
// Results for values above 9999 are replaced by an all-E code so the display shows "EEEE".
module bin2bcd_seq (
  input  logic        clk0,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf
);

  localparam int              DATA_W   = 14;
  localparam int              BCD_W    = 16;
  localparam int              SREG_W   = DATA_W + BCD_W;
  localparam logic [3:0]      LAST_CNT = 4'(DATA_W - 1);
  localparam logic [13:0]     MAX_VAL  = 14'd9999;
  localparam logic [15:0]     OVF_CODE = 16'hEEEE;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [SREG_W-1:0]   sreg;
  logic [SREG_W-1:0]   sreg_nxt;
  logic [3:0]          cnt;
  logic                ovf_lat;
  logic                accept;
  logic                last;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Correct every BCD nibble first, then shift; nibbles never carry into each other.
  function automatic logic [SREG_W-1:0] dabble_step(input logic [SREG_W-1:0] r);
    logic [SREG_W-1:0] a;
    a = r;
    for (int n = 0; n < 4; n++) begin
      a[DATA_W + 4*n +: 4] = add3(r[DATA_W + 4*n +: 4]);
    end
    return {a[SREG_W-2:0], 1'b0};
  endfunction

  assign accept   = (state == IDLE) && start;
  assign last     = (state == SHIFT) && (cnt == LAST_CNT);
  assign sreg_nxt = dabble_step(sreg);

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      cnt     <= '0;
      ovf_lat <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        sreg    <= {{BCD_W{1'b0}}, bin};
        cnt     <= '0;
        ovf_lat <= (bin > MAX_VAL);
      end else if (state == SHIFT) begin
        sreg <= sreg_nxt;
        cnt  <= cnt + 4'd1;
      end
      // Outputs only move on the final shift so the display never sees partial digits.
      if (last) begin
        bcd <= ovf_lat ? OVF_CODE : sreg_nxt[SREG_W-1 -: BCD_W];
        ovf <= ovf_lat;
      end
    end
  end

endmodule
